// File: rtl/iir_biquad_sched.sv
// Time-multiplexed biquad IIR section: one shared multiplier and accumulator
// walk the five taps of each sample, with valid/ready on both sides.
module iir_biquad_sched #(
   parameter int DW   = 12,
   parameter int CW   = 12,
   parameter int FRAC = 10,
   parameter int AW   = DW + CW + 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] x_in,
   input  logic          x_valid,
   output logic          x_ready,
   output logic [DW-1:0] y_out,
   output logic          y_valid,
   input  logic          y_ready,
   input  logic          coe_we,
   input  logic [2:0]    coe_addr,
   input  logic [CW-1:0] coe_wdata,
   input  logic          hist_clr,
   output logic          busy
);

   localparam int PW = CW + DW;
   localparam logic signed [AW-1:0] Y_MAX = AW'((2 ** (DW - 1)) - 1);
   localparam logic signed [AW-1:0] Y_MIN = AW'(-(2 ** (DW - 1)));

   typedef enum logic [2:0] {S_IDLE, S_MAC, S_FLUSH, S_DONE, S_OUT} state_t;

   state_t state, state_nx;

   logic        [2:0]    tap;
   logic signed [DW-1:0] x0, x1, x2, y1, y2;
   logic signed [CW-1:0] b0, b1, b2, a1, a2;
   logic signed [PW-1:0] prod_reg;
   logic signed [PW-1:0] prod_nx;
   logic signed [AW-1:0] prod_ext;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] acc_sh;
   logic signed [DW-1:0] y_sat;
   logic signed [DW-1:0] opnd;
   logic signed [CW-1:0] cf;

   // State register; active-high asynchronous reset aborts any sample in flight.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nx = state;
      x_ready  = 1'b0;
      busy     = 1'b1;
      case (state)
         S_IDLE: begin
            x_ready = 1'b1;
            busy    = 1'b0;
            if (x_valid) state_nx = S_MAC;
         end
         S_MAC:   if (tap == 3'd4) state_nx = S_FLUSH;
         S_FLUSH: state_nx = S_DONE;
         S_DONE:  state_nx = S_OUT;
         S_OUT:   if (y_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Tap operand/coefficient selection and the shared multiplier.
   always_comb begin
      opnd = x0;
      cf   = b0;
      case (tap)
         3'd0: begin opnd = x0; cf = b0; end
         3'd1: begin opnd = x1; cf = b1; end
         3'd2: begin opnd = x2; cf = b2; end
         3'd3: begin opnd = y1; cf = a1; end
         default: begin opnd = y2; cf = a2; end
      endcase
      prod_nx  = cf * opnd;
      prod_ext = {{(AW - PW){prod_reg[PW-1]}}, prod_reg};
   end

   // Floor-shift the accumulator back to sample scale and clamp to DW bits.
   always_comb begin
      acc_sh = acc >>> FRAC;
      y_sat  = acc_sh[DW-1:0];
      if (acc_sh > Y_MAX)      y_sat = {1'b0, {(DW - 1){1'b1}}};
      else if (acc_sh < Y_MIN) y_sat = {1'b1, {(DW - 1){1'b0}}};
   end

   // Datapath: coefficient bank, history, MAC pipeline and output register.
   // The product register lags the tap counter by one cycle, so the sign of
   // each accumulate follows the tap whose product is in prod_reg: taps 3 and 4
   // land at tap==4 and in FLUSH respectively.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         b0       <= CW'(1006);
         b1       <= CW'(-1911);
         b2       <= CW'(1006);
         a1       <= '0;
         a2       <= '0;
         x0       <= '0;
         x1       <= '0;
         x2       <= '0;
         y1       <= '0;
         y2       <= '0;
         tap      <= '0;
         acc      <= '0;
         prod_reg <= '0;
         y_out    <= '0;
         y_valid  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (coe_we) begin
                  case (coe_addr)
                     3'd0: b0 <= coe_wdata;
                     3'd1: b1 <= coe_wdata;
                     3'd2: b2 <= coe_wdata;
                     3'd3: a1 <= coe_wdata;
                     3'd4: a2 <= coe_wdata;
                     default: ;
                  endcase
               end
               if (x_valid) begin
                  x0  <= x_in;
                  tap <= '0;
                  acc <= '0;
               end else if (hist_clr) begin
                  x1 <= '0;
                  x2 <= '0;
                  y1 <= '0;
                  y2 <= '0;
               end
            end
            S_MAC: begin
               prod_reg <= prod_nx;
               if (tap != 3'd0) begin
                  if (tap == 3'd4) acc <= acc - prod_ext;
                  else             acc <= acc + prod_ext;
               end
               tap <= tap + 3'd1;
            end
            S_FLUSH: acc <= acc - prod_ext;
            S_DONE: begin
               y_out   <= y_sat;
               y_valid <= 1'b1;
               x2      <= x1;
               x1      <= x0;
               y2      <= y1;
               y1      <= y_sat;
            end
            S_OUT: if (y_ready) y_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_biquad_sched.sv
// Scenario-driven bench for iir_biquad_sched with an output scoreboard.
module tb_iir_biquad_sched;

   localparam int DW = 12;
   localparam int CW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] x_in = '0;
   logic          x_valid = 1'b0;
   logic          x_ready;
   logic [DW-1:0] y_out;
   logic          y_valid;
   logic          y_ready = 1'b1;
   logic          coe_we = 1'b0;
   logic [2:0]    coe_addr = '0;
   logic [CW-1:0] coe_wdata = '0;
   logic          hist_clr = 1'b0;
   logic          busy;

   iir_biquad_sched #(.DW(DW), .CW(CW), .FRAC(10), .AW(DW + CW + 3)) dut (
      .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
      .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .coe_we(coe_we),
      .coe_addr(coe_addr), .coe_wdata(coe_wdata), .hist_clr(hist_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_q[$];
   int acc_q[$];
   int last_acc = 0;
   logic prev_yv = 1'b0;
   int mon_e;
   int mon_a;
   logic [DW-1:0] mon_ev;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (y_valid && !prev_yv && acc_q.size() > 0) begin
         mon_a = acc_q.pop_front();
         n_assert++;
         if (cyc - mon_a != 7) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, want 7", cyc - mon_a);
         end
      end
      if (y_valid && y_ready) begin
         n_assert++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got y=%0d, none expected", $signed(y_out));
         end else begin
            mon_e  = exp_q.pop_front();
            mon_ev = DW'(mon_e);
            if (y_out !== mon_ev) begin
               n_fail++;
               $display("FAIL y_out: got %0d, want %0d", $signed(y_out), mon_e);
            end
         end
      end
      prev_yv = y_valid;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic send(input int x, input int e);
      int t = 0;
      while (!x_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!x_ready) begin
         n_assert++; n_fail++;
         $display("FAIL send_timeout: x_ready=%b, want 1", x_ready);
      end
      x_in = DW'(x); x_valid = 1'b1;
      @(posedge clk); #1;
      x_valid = 1'b0;
      x_in = DW'(-777);
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      last_acc = cyc;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (!(exp_q.size() == 0 && x_ready) && t < 200) begin @(posedge clk); #1; t++; end
      if (exp_q.size() != 0 || !x_ready) begin
         n_assert++; n_fail++;
         $display("FAIL drain_timeout: pending=%0d, want 0", exp_q.size());
      end
   endtask

   task automatic write_coef(input int a, input int d);
      coe_we = 1'b1; coe_addr = 3'(a); coe_wdata = CW'(d);
      @(posedge clk); #1;
      coe_we = 1'b0;
   endtask

   task automatic hist_clear();
      hist_clr = 1'b1;
      @(posedge clk); #1;
      hist_clr = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_assert++;
      if (x_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got x_ready=%b busy=%b, want 1 0", x_ready, busy);
      end
      n_assert++;
      if (y_valid !== 1'b0 || y_out !== '0) begin
         n_fail++; $display("FAIL reset_out: got y_valid=%b y_out=%0d, want 0 0", y_valid, y_out);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_impulse();
      int prev;
      send(1024, 1006);
      prev = last_acc;
      send(0, -1911);
      n_assert++;
      if (last_acc - prev != 9) begin
         n_fail++; $display("FAIL accept_spacing: got %0d, want 9", last_acc - prev);
      end
      prev = last_acc;
      send(0, 1006);
      n_assert++;
      if (last_acc - prev != 9) begin
         n_fail++; $display("FAIL accept_spacing: got %0d, want 9", last_acc - prev);
      end
      send(0, 0);
      wait_drain();
   endtask

   task automatic test_busy_write();
      hist_clear();
      send(1024, 1006);
      // b0 write attempted while the sample is in MAC.
      coe_we = 1'b1; coe_addr = 3'd0; coe_wdata = '0;
      repeat (3) @(posedge clk);
      #1 coe_we = 1'b0;
      n_assert++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_during_mac: got %b, want 1", busy);
      end
      send(0, -1911);
      wait_drain();
      hist_clear();
      send(1024, 1006);
      wait_drain();
      // Out-of-range addresses must not alias onto any coefficient.
      write_coef(5, 0);
      write_coef(6, 0);
      write_coef(7, 0);
      hist_clear();
      send(1024, 1006);
      send(0, -1911);
      send(0, 1006);
      send(0, 0);
      wait_drain();
   endtask

   task automatic test_pole();
      write_coef(0, 1024);
      write_coef(1, 0);
      write_coef(2, 0);
      write_coef(3, -512);
      write_coef(4, 0);
      hist_clear();
      send(1024, 1024);
      send(0, 512);
      send(0, 256);
      send(0, 128);
      send(0, 64);
      wait_drain();
   endtask

   task automatic test_saturation();
      write_coef(3, 0);
      hist_clear();
      // Write and accept in the same cycle: new b0=2047 must apply (old gives 1024).
      coe_we = 1'b1; coe_addr = 3'd0; coe_wdata = CW'(2047);
      x_valid = 1'b1; x_in = DW'(1024);
      @(posedge clk); #1;
      coe_we = 1'b0; x_valid = 1'b0;
      exp_q.push_back(2047);
      acc_q.push_back(cyc);
      wait_drain();
      hist_clear();
      send(2047, 2047);
      wait_drain();
      hist_clear();
      send(-2048, -2048);
      wait_drain();
   endtask

   task automatic test_back_pressure();
      logic [DW-1:0] snap;
      int t = 0;
      hist_clear();
      y_ready = 1'b0;
      send(1024, 2047);
      while (!y_valid && t < 20) begin @(posedge clk); #1; t++; end
      n_assert++;
      if (!y_valid) begin
         n_fail++; $display("FAIL bp_wait_valid: got y_valid=%b, want 1", y_valid);
      end
      snap = y_out;
      x_valid = 1'b1; x_in = DW'(5);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_assert++;
         if (y_out !== snap || y_valid !== 1'b1 || x_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stable: got y=%0d v=%b rdy=%b, want y=%0d v=1 rdy=0",
                     $signed(y_out), y_valid, x_ready, $signed(snap));
         end
      end
      x_valid = 1'b0;
      n_assert++;
      if (exp_q.size() != 1) begin
         n_fail++; $display("FAIL bp_pending: got %0d, want 1", exp_q.size());
      end
      y_ready = 1'b1;
      @(posedge clk); #1;
      n_assert++;
      if (y_valid !== 1'b0 || x_ready !== 1'b1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_release: got v=%b rdy=%b pending=%0d, want 0 1 0",
                  y_valid, x_ready, exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      send(1024, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      n_assert++;
      if (x_ready !== 1'b1 || y_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got rdy=%b v=%b busy=%b, want 1 0 0", x_ready, y_valid, busy);
      end
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      send(1024, 1006);
      send(0, -1911);
      wait_drain();
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_busy_write();
      test_pole();
      test_saturation();
      test_back_pressure();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/iir_biquad_sched.md
# iir_biquad_sched

Time-multiplexed biquad IIR section controller. Shares one signed DW×CW multiplier and one accumulator across the five taps (b0·x[n], b1·x[n-1], b2·x[n-2], a1·y[n-1], a2·y[n-2]) of each input sample. Owns the x/y history registers and the programmable coefficient bank. Sits between the sample source and the downstream stage, with valid/ready on both sides.

## Interface
- DW, 12: sample width (x_in, y_out), signed
- CW, 12: coefficient width, signed
- FRAC, 10: coefficient fractional bits; output = acc >>> FRAC
- AW, DW+CW+3: accumulator width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
- x_in  in  DW  input sample, signed
- x_valid  in  1  x_in valid
- x_ready  out  1  block can accept a sample
- y_out  out  DW  filtered sample, signed, saturated
- y_valid  out  1  y_out valid
- y_ready  in  1  downstream accepts y_out
- coe_we  in  1  coefficient write strobe
- coe_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 ignored
- coe_wdata  in  CW  coefficient value, signed
- hist_clr  in  1  synchronous clear of x/y history, honoured in IDLE only
- busy  out  1  high in every state except IDLE

## Operation
- Transfer function: y[n] = sat( (b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> FRAC ), where >>> is arithmetic (floor) shift. Saturation clamps to [−2^(DW−1), 2^(DW−1)−1].
- Products are full CW+DW bits, sign-extended to AW before accumulation. The accumulator never wraps for legal inputs.
- States:
  - IDLE: x_ready=1. On x_valid: latch x0=x_in, tap=0, acc=0, go to MAC. Else, if hist_clr: x1, x2, y1, y2 <= 0.
  - MAC: prod_reg <= coef[tap]·operand[tap]. When tap>0, acc <= acc ± prod_reg (taps 3 and 4 subtract). tap++. Go to FLUSH after tap 4.
  - FLUSH: acc <= acc − prod_reg (tap 4 product). Go to DONE.
  - DONE: y_out <= sat(acc >>> FRAC), y_valid <= 1. Shift history: x2<=x1, x1<=x0, y2<=y1, y1<=saturated y. Go to OUT.
  - OUT: hold y_out and y_valid until y_ready. On y_valid & y_ready: y_valid <= 0, go to IDLE.
- Coefficient writes:
  - Accepted only in IDLE with coe_addr ≤ 4.
  - Writes while busy, or to addr 5–7, are dropped silently.
  - A write and an x_valid handshake in the same IDLE cycle: the write lands first, and the new coefficient is used for that sample.
- Coefficient reset values: b0=1006, b1=−1911, b2=1006, a1=0, a2=0 (pure zero section).
- x_in is sampled only on the handshake. Changes to x_in after that are ignored.

## Timing
- Reset values:
  - state=IDLE; x_ready=1, y_valid=0, y_out=0, busy=0.
  - All history registers, acc and prod_reg = 0.
  - Coefficients at the defaults above.
- Reset asserted mid-operation aborts the sample immediately. No partial y_out is emitted and no history is updated.
- Latency: x_valid & x_ready sampled at edge E0.
  - MAC occupies E1–E5, FLUSH is E6, DONE is E7.
  - y_valid is high after E7, i.e. 7 cycles after acceptance.
- Throughput with y_ready=1: OUT completes at E8 and IDLE follows. The next accept is at E9, so one sample per 9 cycles.
- x_ready is 0 from E0+ until return to IDLE. busy = ~x_ready.
- Back-pressure: y_out and y_valid stay stable for any number of cycles with y_ready=0. No new input is accepted during that time.
- hist_clr and x_valid in the same IDLE cycle: the accept wins and the clear is ignored.

## Test plan
- Reset defaults, impulse test:
  - Stimulus: x = 1024, 0, 0, 0, with y_ready=1.
  - Required: y = 1006, −1911, 1006, 0.
  - Required: each y_valid occurs exactly 7 cycles after its accept; accepts are 9 cycles apart.
- Pole path:
  - Stimulus: write b0=1024, b1=0, b2=0, a1=−512, a2=0, then impulse 1024 followed by zeros.
  - Required: y = 1024, 512, 256, 128, 64.
- Saturation:
  - b0=2047, b1=b2=0, x=2047 → y=2047 (raw 4092).
  - x=−2048 → y=−2048 (raw −4094).
- Back-pressure:
  - Stimulus: hold y_ready=0 for 5 cycles after y_valid rises.
  - Required: y_out, y_valid and x_ready=0 all stable; a single transfer happens when y_ready rises; state then returns to IDLE.
- Illegal and busy writes:
  - coe_we to b0 during MAC is dropped; the next output still uses 1006.
  - A write to addr 6 in IDLE has no effect on any coefficient.
- Async reset at E3:
  - Required: x_ready=1 and y_valid=0 immediately.
  - Required: history cleared; a following impulse 1024 gives 1006 again.
